// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, load/store port and unified-memory port around mem_port_arbiter.
// slave is the arbiter's view; master is the requesters plus memory driving it.
interface mem_port_arbiter_if #(
    parameter int BIT_COUNT = 32
);
    logic                   i_req;
    logic [BIT_COUNT-1:0]   i_addr;
    logic                   i_ready;
    logic [BIT_COUNT-1:0]   i_rdata;

    logic                   d_req;
    logic                   d_we;
    logic [BIT_COUNT-1:0]   d_addr;
    logic [BIT_COUNT-1:0]   d_wdata;
    logic [BIT_COUNT/8-1:0] d_wmask;
    logic                   d_ready;
    logic [BIT_COUNT-1:0]   d_rdata;

    logic                   m_req;
    logic                   m_we;
    logic [BIT_COUNT-1:0]   m_addr;
    logic [BIT_COUNT-1:0]   m_wdata;
    logic [BIT_COUNT/8-1:0] m_wmask;
    logic [BIT_COUNT-1:0]   m_rdata;
    logic                   m_ack;

    logic                   bus_error;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, m_rdata, m_ack,
        output i_ready, i_rdata, d_ready, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_wmask, bus_error
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, m_rdata, m_ack,
        input  i_ready, i_rdata, d_ready, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_wmask, bus_error
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch and load/store; data wins, fetch starvation bounded.
// Latency: m_req registered at the grant edge; ready pulses combinationally on m_ack. Watchdog aborts hung accesses.
module mem_port_arbiter #(
    parameter int BIT_COUNT       = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int MW = BIT_COUNT / 8;
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [WW-1:0] WDOG_MAX   = WW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_m_req;
    logic                   r_m_we;
    logic [BIT_COUNT-1:0]   r_m_addr;
    logic [BIT_COUNT-1:0]   r_m_wdata;
    logic [MW-1:0]          r_m_wmask;
    logic [SW-1:0]          r_streak;
    logic [WW-1:0]          r_wdog;
    logic                   r_bus_error;

    logic w_grant_d;
    logic w_grant_i;
    logic w_busy;
    logic w_done;
    logic w_timeout;
    logic w_finish;

    // Fetch only beats a pending data request once data has won STREAK_MAX times in a row.
    always_comb begin
        w_grant_d = bus.d_req && (!bus.i_req || (r_streak != STREAK_MAX));
        w_grant_i = bus.i_req && !w_grant_d;
        w_busy    = (r_state != ST_IDLE);
        w_done    = w_busy && bus.m_ack;
        w_timeout = (TIMEOUT_CYCLES > 0) && w_busy && !bus.m_ack && (r_wdog == WDOG_MAX);
        w_finish  = w_done || w_timeout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = ST_BUSY_D;
                end else if (w_grant_i) begin
                    w_state_nxt = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (w_finish) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.i_ready   = (r_state == ST_BUSY_I) && w_finish;
        bus.d_ready   = (r_state == ST_BUSY_D) && w_finish;
        bus.i_rdata   = ((r_state == ST_BUSY_I) && w_done) ? bus.m_rdata : '0;
        bus.d_rdata   = ((r_state == ST_BUSY_D) && w_done) ? bus.m_rdata : '0;
        bus.m_req     = r_m_req;
        bus.m_we      = r_m_we;
        bus.m_addr    = r_m_addr;
        bus.m_wdata   = r_m_wdata;
        bus.m_wmask   = r_m_wmask;
        bus.bus_error = r_bus_error;
    end

    // Request fields are latched at the grant, so a requester dropping early cannot corrupt the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_req     <= 1'b0;
            r_m_we      <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_m_wmask   <= '0;
            r_streak    <= '0;
            r_wdog      <= '0;
            r_bus_error <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_grant_d) begin
                r_m_req   <= 1'b1;
                r_m_we    <= bus.d_we;
                r_m_addr  <= bus.d_addr;
                r_m_wdata <= bus.d_wdata;
                r_m_wmask <= bus.d_wmask;
                r_wdog    <= '0;
                if (bus.i_req && (r_streak != STREAK_MAX)) begin
                    r_streak <= r_streak + 1'b1;
                end
            end else if (w_grant_i) begin
                r_m_req   <= 1'b1;
                r_m_we    <= 1'b0;
                r_m_addr  <= bus.i_addr;
                r_m_wdata <= '0;
                r_m_wmask <= '0;
                r_wdog    <= '0;
                r_streak  <= '0;
            end
        end else begin
            if (w_finish) begin
                r_m_req <= 1'b0;
                if (w_timeout) begin
                    r_bus_error <= 1'b1;
                end
            end else if ((TIMEOUT_CYCLES > 0) && !bus.m_ack) begin
                r_wdog <= r_wdog + 1'b1;
            end
        end
    end
endmodule
